// File: rtl/mult_result_uart_tx_if.sv
// rtl/mult_result_uart_tx_if.sv - product handshake bus between the multiplier and the UART transmitter
interface mult_result_uart_tx_if #(
   parameter int WIDTH = 8
);
   logic [2*WIDTH-1:0] res_in;
   logic               res_valid;
   logic               res_ready;

   modport master (output res_in, output res_valid, input res_ready);
   modport slave  (input res_in, input res_valid, output res_ready);
endinterface

// File: rtl/mult_result_uart_tx.sv
// rtl/mult_result_uart_tx.sv - serialise a captured product as LSB-first UART bytes (8N1)
// Optional feature macro: MULT_TX_PARITY_EN inserts an even-parity bit after each data byte.
module mult_result_uart_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   mult_result_uart_tx_if.slave res,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);
   localparam int PW     = 2 * WIDTH;
   localparam int NBYTES = (PW + 7) / 8;
   localparam int SW     = NBYTES * 8;
   localparam int BW     = $clog2(CLKS_PER_BIT);
   localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] BYTE_LAST = IW'(NBYTES - 1);

`ifdef MULT_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t          state_q, state_n;
   logic [BW-1:0]   baud_q, baud_n;
   logic [2:0]      bit_q, bit_n;
   logic [IW-1:0]   byte_q, byte_n;
   logic [SW-1:0]   shreg_q, shreg_n;
   logic            done_q, done_n;
   logic            baud_wrap;
`ifdef MULT_TX_PARITY_EN
   logic            par_q, par_n;
`endif

   assign baud_wrap     = (baud_q == BAUD_LAST);
   assign res.res_ready = (state_q == S_IDLE);
   assign busy          = (state_q != S_IDLE);
   assign done          = done_q;

   // The shift register moves one bit per data bit, so the next byte lands in [7:0] by itself.
   always_comb begin
      state_n = state_q;
      baud_n  = baud_q;
      bit_n   = bit_q;
      byte_n  = byte_q;
      shreg_n = shreg_q;
      done_n  = 1'b0;
      tx      = 1'b1;
`ifdef MULT_TX_PARITY_EN
      par_n   = par_q;
`endif
      if (state_q != S_IDLE) begin
         baud_n = baud_wrap ? '0 : baud_q + 1'b1;
      end
      case (state_q)
         S_IDLE: begin
            tx = 1'b1;
            if (res.res_valid) begin
               state_n           = S_START;
               shreg_n           = '0;
               shreg_n[PW-1:0]   = res.res_in;
               byte_n            = '0;
               bit_n             = '0;
               baud_n            = '0;
            end
         end
         S_START: begin
            tx = 1'b0;
            if (baud_wrap) begin
               state_n = S_DATA;
               bit_n   = '0;
`ifdef MULT_TX_PARITY_EN
               par_n   = 1'b0;
`endif
            end
         end
         S_DATA: begin
            tx = shreg_q[0];
            if (baud_wrap) begin
               shreg_n = shreg_q >> 1;
`ifdef MULT_TX_PARITY_EN
               par_n   = par_q ^ shreg_q[0];
`endif
               if (bit_q == 3'd7) begin
`ifdef MULT_TX_PARITY_EN
                  state_n = S_PARITY;
`else
                  state_n = S_STOP;
`endif
               end else begin
                  bit_n = bit_q + 3'd1;
               end
            end
         end
`ifdef MULT_TX_PARITY_EN
         S_PARITY: begin
            tx = par_q;
            if (baud_wrap) state_n = S_STOP;
         end
`endif
         S_STOP: begin
            tx = 1'b1;
            if (baud_wrap) begin
               if (byte_q == BYTE_LAST) begin
                  state_n = S_IDLE;
                  done_n  = 1'b1;
               end else begin
                  byte_n  = byte_q + 1'b1;
                  state_n = S_START;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shreg_q <= '0;
         done_q  <= 1'b0;
`ifdef MULT_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_n;
         baud_q  <= baud_n;
         bit_q   <= bit_n;
         byte_q  <= byte_n;
         shreg_q <= shreg_n;
         done_q  <= done_n;
`ifdef MULT_TX_PARITY_EN
         par_q   <= par_n;
`endif
      end
   end
endmodule

// File: tb/tb_mult_result_uart_tx.sv
// tb/tb_mult_result_uart_tx.sv - frame-level model plus directed vectors for mult_result_uart_tx
module tb_mult_result_uart_tx;
   localparam int CPB = 16;
`ifdef MULT_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   logic clk, rst;
   logic tx8, busy8, done8, tx2, busy2, done2;
   int   checks = 0;
   int   passes = 0;
   int   found;
   int   bad;
   logic [63:0] got;

   mult_result_uart_tx_if #(.WIDTH(8)) bus8 ();
   mult_result_uart_tx_if #(.WIDTH(2)) bus2 ();

   mult_result_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB)) dut8 (
      .clk(clk), .rst(rst), .res(bus8), .tx(tx8), .busy(busy8), .done(done8));
   mult_result_uart_tx #(.WIDTH(2), .CLKS_PER_BIT(CPB)) dut2 (
      .clk(clk), .rst(rst), .res(bus2), .tx(tx2), .busy(busy2), .done(done2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: a product becomes a list of line bits, each held CPB cycles.
   function automatic logic [63:0] build(input logic [15:0] p, input int nb);
      logic [63:0] f = '1;
      int n = 0;
      logic [7:0] b;
      for (int k = 0; k < nb; k++) begin
         b = p[8*k +: 8];
         f[n] = 1'b0; n++;
         for (int j = 0; j < 8; j++) begin f[n] = b[j]; n++; end
         if (FB == 11) begin f[n] = ^b; n++; end
         f[n] = 1'b1; n++;
      end
      return f;
   endfunction

   logic [63:0] m_frame [2];
   int          m_pos   [2];
   bit          m_act   [2];
   bit          m_done  [2];
   logic        s_rst;
   logic        s_v [2];
   logic [15:0] s_d [2];

   always @(posedge clk) begin
      s_rst  <= rst;
      s_v[0] <= bus8.res_valid;
      s_v[1] <= bus2.res_valid;
      s_d[0] <= bus8.res_in;
      s_d[1] <= 16'(bus2.res_in);
   end

   task automatic model_step(input int d, input int nb);
      bit was;
      was       = m_act[d];
      m_done[d] = 1'b0;
      if (s_rst === 1'b1) begin
         m_act[d] = 1'b0;
         m_pos[d] = 0;
      end else if (was) begin
         m_pos[d]++;
         if (m_pos[d] == nb * FB * CPB) begin
            m_act[d]  = 1'b0;
            m_done[d] = 1'b1;
         end
      end else if (s_v[d] === 1'b1) begin
         m_frame[d] = build(s_d[d], nb);
         m_act[d]   = 1'b1;
         m_pos[d]   = 0;
      end
   endtask

   function automatic logic exp_tx(input int d);
      return m_act[d] ? m_frame[d][m_pos[d] / CPB] : 1'b1;
   endfunction

   always @(negedge clk) begin
      model_step(0, 2);
      model_step(1, 1);
      chk("m_tx8",    tx8,            exp_tx(0));
      chk("m_busy8",  busy8,          m_act[0]);
      chk("m_ready8", bus8.res_ready, !m_act[0]);
      chk("m_done8",  done8,          m_done[0]);
      chk("m_tx2",    tx2,            exp_tx(1));
      chk("m_busy2",  busy2,          m_act[1]);
      chk("m_ready2", bus2.res_ready, !m_act[1]);
      chk("m_done2",  done2,          m_done[1]);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_done(input int d, input int limit, output int cyc);
      cyc = -1;
      got = '1;
      for (int i = 1; i <= limit; i++) begin
         tick();
         if (i % CPB == CPB / 2) got[i / CPB] = (d == 0) ? tx8 : tx2;
         if (((d == 0) ? done8 : done2) === 1'b1) begin
            cyc = i;
            break;
         end
      end
   endtask

   function automatic logic [7:0] byte_at(input int s);
      logic [7:0] b;
      for (int j = 0; j < 8; j++) b[j] = got[s + j];
      return b;
   endfunction

   task automatic send8(input logic [15:0] v);
      bus8.res_in    = v;
      bus8.res_valid = 1'b1;
      tick();
      bus8.res_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus8.res_valid = 1'b0; bus8.res_in = '0;
      bus2.res_valid = 1'b0; bus2.res_in = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_tx",    tx8, 1'b1);
      chk("rst_ready", bus8.res_ready, 1'b1);
      chk("rst_busy",  busy8, 1'b0);
      chk("rst_done",  done8, 1'b0);

      bad = 0;
      repeat (1000) begin
         tick();
         if (tx8 !== 1'b1 || done8 !== 1'b0) bad++;
      end
      chk("idle_quiet", bad, 0);

      send8(16'h1234);
      chk("t1_latency", tx8, 1'b0);
      chk("t1_busy", busy8, 1'b1);
      wait_done(0, 1000, found);
      chk("t1_done_cycles", found, 2 * FB * CPB);
      chk("t1_byte0", byte_at(1), 8'h34);
      chk("t1_byte1", byte_at(FB + 1), 8'h12);
`ifdef MULT_TX_PARITY_EN
      chk("t1_par0", got[9], 1'b1);
      chk("t1_par1", got[FB + 9], 1'b0);
`endif
      chk("t1_ready_at_done", bus8.res_ready, 1'b1);
      chk("t1_busy_at_done", busy8, 1'b0);

      bus2.res_in = 4'd6;
      bus2.res_valid = 1'b1;
      tick();
      bus2.res_valid = 1'b0;
      chk("w2_latency", tx2, 1'b0);
      wait_done(1, 1000, found);
      chk("w2_done_cycles", found, FB * CPB);
      chk("w2_byte", byte_at(1), 8'h06);
      chk("w2_ready_at_done", bus2.res_ready, 1'b1);

      bus8.res_in = 16'hABCD;
      bus8.res_valid = 1'b1;
      tick();
      chk("bp_latency", tx8, 1'b0);
      bus8.res_in = 16'h5555;
      wait_done(0, 1000, found);
      chk("bp_done_cycles", found, 2 * FB * CPB);
      chk("bp_byte0", byte_at(1), 8'hCD);
      chk("bp_byte1", byte_at(FB + 1), 8'hAB);
      chk("bp_ready_at_done", bus8.res_ready, 1'b1);
      tick();
      bus8.res_valid = 1'b0;
      chk("bp_back_to_back", tx8, 1'b0);
      chk("bp_busy_again", busy8, 1'b1);
      wait_done(0, 1000, found);
      chk("bp2_done_cycles", found, 2 * FB * CPB);
      chk("bp2_byte0", byte_at(1), 8'h55);
      chk("bp2_byte1", byte_at(FB + 1), 8'h55);

      send8(16'h1234);
      repeat (CPB * 4 + 5) tick();
      chk("mr_busy_before", busy8, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_tx",    tx8, 1'b1);
      chk("mr_ready", bus8.res_ready, 1'b1);
      chk("mr_busy",  busy8, 1'b0);
      bad = 0;
      repeat (400) begin
         tick();
         if (done8 !== 1'b0) bad++;
      end
      chk("mr_no_done", bad, 0);

      send8(16'h00A5);
      chk("mr2_latency", tx8, 1'b0);
      wait_done(0, 1000, found);
      chk("mr2_done_cycles", found, 2 * FB * CPB);
      chk("mr2_byte0", byte_at(1), 8'hA5);
      chk("mr2_byte1", byte_at(FB + 1), 8'h00);

      repeat (4) tick();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/mult_result_uart_tx.md
Name: mult_result_uart_tx

Overview:
- Downstream stage of the combinational multiplier in the UART task.
- Captures the 2*WIDTH-bit product with a valid/ready handshake, splits it into bytes and serialises them on a UART TX line (8N1, LSB first).
- Sits between the multiplier's out bus and the board TX pin.
- Single clock domain; no FIFO, one product in flight at a time.

Parameters:
- WIDTH, 8, operand width of the upstream multiplier; product width is 2*WIDTH.
- CLKS_PER_BIT, 16, clk cycles per UART bit (must be >= 2).
- Derived localparam NBYTES = ceil(2*WIDTH/8); upper unused bits of the last byte are zero-padded.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- res_in  in  2*WIDTH  product from multiplier out.
- res_valid  in  1  res_in holds a product to send.
- res_ready  out  1  block can accept a product (high only in IDLE).
- tx  out  1  UART serial output, idle high.
- busy  out  1  high from capture until done.
- done  out  1  one-cycle pulse after stop bit of last byte.

Behaviour:
- Reset values: tx=1, res_ready=1, busy=0, done=0; FSM=IDLE; bit counter, byte index and baud counter =0.
- Handshake:
  - Capture occurs on a clk edge with res_valid && res_ready.
  - res_in is latched into an internal shift register; later changes to res_in are ignored.
  - res_ready drops the cycle after capture.
- FSM states: IDLE -> START -> DATA -> STOP -> (START for next byte | IDLE).
  - IDLE: tx=1. On capture go to START; byte index=0.
  - START: tx=0 for CLKS_PER_BIT cycles. The first start-bit cycle is the cycle immediately after the capture edge (latency 1).
  - DATA: 8 bits of the current byte, bit0 first, each held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At its end:
    - if byte index < NBYTES-1: increment index, go to START with no idle gap;
    - else: go to IDLE and pulse done.
- Byte order: least significant byte first (byte k = product bits [8k+7:8k]).
- Frame timing: 10*CLKS_PER_BIT cycles per byte; NBYTES*10*CLKS_PER_BIT cycles from first tx fall to done.
- done, res_ready and busy timing:
  - done asserts in the first IDLE cycle.
  - res_ready is also 1 in that same cycle; busy=0.
  - A capture is allowed in the same cycle done is high.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps; bit advance happens on the wrap.
- Reset mid-operation: on the next edge all state returns to reset values, tx=1 immediately, partial frame abandoned, no done pulse.
- res_valid low in IDLE: block stays idle indefinitely, tx=1.

Optional Feature:
- Macro: MULT_TX_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the 8 data bits) is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - Frame = 11*CLKS_PER_BIT cycles.
  - FSM gains a PARITY state.
- Undefined: no PARITY state; 8N1 frames as above.

Test Plan:
- WIDTH=8, CLKS_PER_BIT=16, res_in=16'h1234 pulsed valid for 1 cycle:
  - tx low starting 1 cycle after capture.
  - Byte 0x34 sent first, bits 0,0,1,0,1,1,0,0; then 0x12.
  - done pulses exactly 320 cycles after first tx fall.
  - busy=1 throughout.
- WIDTH=2, product of a=2,b=3 (res_in=4'd6):
  - NBYTES=1, single frame carrying 0x06.
  - done after 160 cycles; res_ready=1 in the same cycle.
- Backpressure: hold res_valid=1 with res_in=16'hABCD, then change res_in to 16'h5555 during transmission:
  - Only 0xCD, 0xAB are sent.
  - 0x5555 is captured on the done cycle and sent next, back to back.
- Reset mid-frame: assert rst during DATA bit 3 of byte 0:
  - Next cycle tx=1, res_ready=1, busy=0, done never pulses.
  - A new capture afterwards transmits correctly.
- Idle: res_valid=0 for 1000 cycles after reset → tx constant 1, done never asserted.
- With MULT_TX_PARITY_EN, res_in=16'h1234:
  - Parity bit 1 after 0x34, parity bit 0 after 0x12.
  - done 352 cycles after first tx fall.
